// File: rtl/boot_controller.sv
// Boot sequencer: holds the CPU in reset while the copier moves EEPROM into RAM,
// then hands the memory bus over to the CPU. A copy that never finishes ends in FAULT.
module boot_controller #(
   parameter int SETTLE_CYCLES    = 4,
   parameter int CPU_RESET_CYCLES = 8,
   parameter int COPY_TIMEOUT     = 65535
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        copier_reset_n,
   input  logic        copier_done,
   input  logic [15:0] copier_address,
   input  logic        copier_ram_we_n,
   input  logic        copier_ram_cs_n,
   input  logic        copier_eeprom_oe_n,
   input  logic        copier_eeprom_cs_n,
   input  logic [15:0] cpu_address,
   input  logic        cpu_mreq_n,
   input  logic        cpu_rd_n,
   input  logic        cpu_wr_n,
   output logic [15:0] address,
   output logic        ram_cs_n,
   output logic        ram_oe_n,
   output logic        ram_we_n,
   output logic        eeprom_cs_n,
   output logic        eeprom_oe_n,
   output logic        cpu_reset_n,
   output logic        boot_done,
   output logic        fault
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      COPY      = 3'd1,
      SETTLE    = 3'd2,
      CPU_RESET = 3'd3,
      RUN       = 3'd4,
      FAULT     = 3'd5
   } state_t;

   localparam logic [15:0] TIMEOUT_LAST   = 16'(COPY_TIMEOUT - 1);
   localparam logic [15:0] SETTLE_LAST    = 16'(SETTLE_CYCLES - 1);
   localparam logic [15:0] CPU_RESET_LAST = 16'(CPU_RESET_CYCLES - 1);

   state_t      state;
   state_t      state_next;
   logic [15:0] count;
   logic [15:0] count_next;

   // Reset outputs are registered from the next state so they track the state without glitches.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state          <= IDLE;
         count          <= '0;
         copier_reset_n <= 1'b0;
         cpu_reset_n    <= 1'b0;
      end else begin
         state          <= state_next;
         count          <= count_next;
         copier_reset_n <= (state_next != IDLE);
         cpu_reset_n    <= (state_next == RUN);
      end
   end

   always_comb begin
      state_next = state;
      count_next = count;
      case (state)
         IDLE: begin
            state_next = COPY;
            count_next = '0;
         end
         COPY: begin
            if (copier_done) begin
               state_next = SETTLE;
               count_next = '0;
            end else if (count == TIMEOUT_LAST) begin
               state_next = FAULT;
            end else begin
               count_next = count + 16'd1;
            end
         end
         SETTLE: begin
            if (count == SETTLE_LAST) begin
               state_next = CPU_RESET;
               count_next = '0;
            end else begin
               count_next = count + 16'd1;
            end
         end
         CPU_RESET: begin
            if (count == CPU_RESET_LAST) begin
               state_next = RUN;
               count_next = '0;
            end else begin
               count_next = count + 16'd1;
            end
         end
         RUN:     state_next = RUN;
         FAULT:   state_next = FAULT;
         default: state_next = FAULT;
      endcase
   end

   // Bus ownership: copier in COPY, CPU in RUN, everything parked otherwise.
   always_comb begin
      address     = 16'h0000;
      ram_cs_n    = 1'b1;
      ram_oe_n    = 1'b1;
      ram_we_n    = 1'b1;
      eeprom_cs_n = 1'b1;
      eeprom_oe_n = 1'b1;
      case (state)
         COPY: begin
            address     = copier_address;
            ram_cs_n    = copier_ram_cs_n;
            ram_we_n    = copier_ram_we_n;
            eeprom_cs_n = copier_eeprom_cs_n;
            eeprom_oe_n = copier_eeprom_oe_n;
         end
         RUN: begin
            address  = cpu_address;
            ram_cs_n = cpu_mreq_n;
            ram_oe_n = cpu_mreq_n | cpu_rd_n;
            ram_we_n = cpu_mreq_n | cpu_wr_n;
         end
         default: ;
      endcase
   end

   assign boot_done = (state == RUN);
   assign fault     = (state == FAULT);

endmodule

// File: tb/tb_boot_controller.sv
// Randomised bench for boot_controller: a timeline model predicts the bus and status
// outputs each cycle, and a negedge monitor compares them against the DUT.
module tb_boot_controller;

   localparam int SETTLE  = 4;
   localparam int CPURST  = 8;
   localparam int TIMEOUT = 100;

   localparam int P_IDLE   = 0;
   localparam int P_COPY   = 1;
   localparam int P_SETTLE = 2;
   localparam int P_CPURST = 3;
   localparam int P_RUN    = 4;
   localparam int P_FAULT  = 5;

   logic        clock;
   logic        reset_n;
   logic        copier_reset_n;
   logic        copier_done;
   logic [15:0] copier_address;
   logic        copier_ram_we_n;
   logic        copier_ram_cs_n;
   logic        copier_eeprom_oe_n;
   logic        copier_eeprom_cs_n;
   logic [15:0] cpu_address;
   logic        cpu_mreq_n;
   logic        cpu_rd_n;
   logic        cpu_wr_n;
   logic [15:0] address;
   logic        ram_cs_n;
   logic        ram_oe_n;
   logic        ram_we_n;
   logic        eeprom_cs_n;
   logic        eeprom_oe_n;
   logic        cpu_reset_n;
   logic        boot_done;
   logic        fault;

   boot_controller #(
      .SETTLE_CYCLES    (SETTLE),
      .CPU_RESET_CYCLES (CPURST),
      .COPY_TIMEOUT     (TIMEOUT)
   ) dut (
      .clock              (clock),
      .reset_n            (reset_n),
      .copier_reset_n     (copier_reset_n),
      .copier_done        (copier_done),
      .copier_address     (copier_address),
      .copier_ram_we_n    (copier_ram_we_n),
      .copier_ram_cs_n    (copier_ram_cs_n),
      .copier_eeprom_oe_n (copier_eeprom_oe_n),
      .copier_eeprom_cs_n (copier_eeprom_cs_n),
      .cpu_address        (cpu_address),
      .cpu_mreq_n         (cpu_mreq_n),
      .cpu_rd_n           (cpu_rd_n),
      .cpu_wr_n           (cpu_wr_n),
      .address            (address),
      .ram_cs_n           (ram_cs_n),
      .ram_oe_n           (ram_oe_n),
      .ram_we_n           (ram_we_n),
      .eeprom_cs_n        (eeprom_cs_n),
      .eeprom_oe_n        (eeprom_oe_n),
      .cpu_reset_n        (cpu_reset_n),
      .boot_done          (boot_done),
      .fault              (fault)
   );

   // clock / reset
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // scoreboard state
   logic [24:0] exp_q[$];
   string       name_q[$];
   int          checks = 0;
   int          errors = 0;

   // model state: k = clock edges since the last edge that saw reset_n low
   int k     = 0;
   int d     = 0;   // COPY cycle (1-based) on which done is driven; 0 = never
   int run   = 0;
   bit known = 1'b0;

   // Phase as a function of time since reset and the planned done cycle.
   function automatic int phase_of(input int kk, input int dd);
      if (kk == 0) return P_IDLE;
      if (dd == 0) return (kk <= TIMEOUT) ? P_COPY : P_FAULT;
      if (kk <= dd) return P_COPY;
      if (kk <= dd + SETTLE) return P_SETTLE;
      if (kk <= dd + SETTLE + CPURST) return P_CPURST;
      return P_RUN;
   endfunction

   function automatic logic [24:0] expect_of(input int ph);
      logic [15:0] a;
      logic [4:0]  s;
      a = 16'h0000;
      s = 5'b11111;
      if (ph == P_COPY) begin
         a = copier_address;
         s = {copier_ram_cs_n, 1'b1, copier_ram_we_n, copier_eeprom_cs_n, copier_eeprom_oe_n};
      end else if (ph == P_RUN) begin
         a = cpu_address;
         s = {cpu_mreq_n, cpu_mreq_n | cpu_rd_n, cpu_mreq_n | cpu_wr_n, 1'b1, 1'b1};
      end
      return {a, s, ph != P_IDLE, ph == P_RUN, ph == P_RUN, ph == P_FAULT};
   endfunction

   // driver: one cycle, with reset_n held low when rst is set
   task automatic drive_cycle(input bit rst);
      int ph;
      @(posedge clock);
      if (!reset_n) begin
         k     = 0;
         known = 1'b1;
      end else if (known) begin
         k++;
      end
      #1;
      reset_n            = rst ? 1'b0 : 1'b1;
      ph                 = phase_of(k, d);
      copier_address     = 16'($urandom);
      copier_ram_we_n    = 1'($urandom);
      copier_ram_cs_n    = 1'($urandom);
      copier_eeprom_oe_n = 1'($urandom);
      copier_eeprom_cs_n = 1'($urandom);
      cpu_address        = 16'($urandom);
      cpu_mreq_n         = 1'($urandom);
      cpu_rd_n           = 1'($urandom);
      cpu_wr_n           = 1'($urandom);
      if (ph == P_COPY && k == 5) begin
         copier_address  = 16'hE123;
         copier_ram_we_n = 1'b0;
      end
      if (ph == P_RUN && k == d + SETTLE + CPURST + 1) begin
         cpu_address = 16'h1234;
         cpu_mreq_n  = 1'b0;
         cpu_rd_n    = 1'b0;
         cpu_wr_n    = 1'b1;
      end
      if (ph == P_COPY) copier_done = (d != 0 && k == d);
      else              copier_done = 1'($urandom_range(0, 1));
      if (known) begin
         exp_q.push_back(expect_of(ph));
         name_q.push_back($sformatf("run%0d_k%0d_ph%0d", run, k, ph));
      end
   endtask

   task automatic do_run(input int rst_len, input int done_at, input int len);
      for (int i = 0; i < rst_len; i++) drive_cycle(1'b1);
      d = done_at;
      for (int i = 0; i < len; i++) drive_cycle(1'b0);
      run++;
   endtask

   // monitor
   initial begin
      logic [24:0] exp_v;
      logic [24:0] act_v;
      string       nm;
      forever begin
         @(negedge clock);
         if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act_v = {address, ram_cs_n, ram_oe_n, ram_we_n, eeprom_cs_n, eeprom_oe_n,
                     copier_reset_n, cpu_reset_n, boot_done, fault};
            checks++;
            if (act_v !== exp_v) begin
               errors++;
               $display("FAIL %s got=%h exp=%h (addr,cs,oe,we,ecs,eoe,crst,cpurst,done,fault)",
                        nm, act_v, exp_v);
            end
         end
      end
   end

   // stimulus
   initial begin
      reset_n            = 1'b0;
      copier_done        = 1'b0;
      copier_address     = 16'h0;
      copier_ram_we_n    = 1'b1;
      copier_ram_cs_n    = 1'b1;
      copier_eeprom_oe_n = 1'b1;
      copier_eeprom_cs_n = 1'b1;
      cpu_address        = 16'h0;
      cpu_mreq_n         = 1'b1;
      cpu_rd_n           = 1'b1;
      cpu_wr_n           = 1'b1;

      do_run(3, 40, 70);                        // nominal boot, then spurious done in RUN
      do_run(2, 0, 120);                        // timeout, then spurious done in FAULT
      do_run(2, TIMEOUT, 125);                  // done coincides with the last COPY cycle
      do_run(1, 40, 40 + 2);                    // abort in the middle of SETTLE
      do_run(1, 40, 70);                        // same sequence again after the abort
      do_run(1, 60, 20);                        // abort mid-COPY
      do_run(1, 1, 30);                         // done on the very first COPY cycle
      for (int r = 0; r < 12; r++) begin
         int dd;
         dd = $urandom_range(0, 110);
         if (dd > TIMEOUT) dd = 0;
         do_run($urandom_range(1, 3), dd, $urandom_range(1, 130));
      end
      drive_cycle(1'b1);

      repeat (3) @(negedge clock);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d exp=0 pending", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/boot_controller.md
BOOT_CONTROLLER -- requirements
Module: boot_controller

Interface
REQ-001 The block SHALL use reset reset_n, synchronous, active-low; clock clock.
REQ-002 Parameters SHALL be:
- SETTLE_CYCLES, 4: bus-idle cycles between copy completion and CPU reset phase.
- CPU_RESET_CYCLES, 8: cycles cpu_reset_n is held low after settle.
- COPY_TIMEOUT, 65535: maximum COPY-state cycles before fault. Legal range 1..65535.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clock, in, 1: system clock.
- reset_n, in, 1: synchronous active-low reset.
- copier_reset_n, out, 1: synchronous reset to the EEPROM-to-RAM copier.
- copier_done, in, 1: copier finished.
- copier_address, in, 16: copier address.
- copier_ram_we_n, in, 1: copier RAM write strobe.
- copier_ram_cs_n, in, 1: copier RAM select.
- copier_eeprom_oe_n, in, 1: copier EEPROM output enable.
- copier_eeprom_cs_n, in, 1: copier EEPROM select.
- cpu_address, in, 16: CPU address.
- cpu_mreq_n, in, 1: CPU memory request.
- cpu_rd_n, in, 1: CPU read strobe.
- cpu_wr_n, in, 1: CPU write strobe.
- address, out, 16: memory address bus.
- ram_cs_n, out, 1: RAM select.
- ram_oe_n, out, 1: RAM output enable.
- ram_we_n, out, 1: RAM write enable.
- eeprom_cs_n, out, 1: EEPROM select.
- eeprom_oe_n, out, 1: EEPROM output enable.
- cpu_reset_n, out, 1: CPU reset.
- boot_done, out, 1: CPU running from RAM.
- fault, out, 1: copy timed out.

Function
REQ-004 The states SHALL be IDLE, COPY, SETTLE, CPU_RESET, RUN and FAULT, held in a registered state register with a single 16-bit cycle counter.
REQ-005 IDLE SHALL last exactly 1 cycle, then go to COPY with the counter cleared.
REQ-006 copier_reset_n SHALL be a register that is 0 in IDLE and 1 in every other state.
REQ-007 COPY transitions:
- copier_done=1: go to SETTLE and clear the counter.
- Else, counter == COPY_TIMEOUT-1: go to FAULT.
- Else: increment the counter.
REQ-008 When copier_done and the timeout coincide, done SHALL take priority (go to SETTLE).
REQ-009 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to CPU_RESET with the counter cleared.
REQ-010 CPU_RESET SHALL last exactly CPU_RESET_CYCLES cycles, then go to RUN.
REQ-011 RUN and FAULT SHALL be terminal until reset_n=0.
REQ-012 copier_done SHALL be ignored outside COPY.
REQ-013 cpu_reset_n SHALL be a register that is 1 only in RUN.
REQ-014 boot_done SHALL be 1 only in RUN; fault SHALL be 1 only in FAULT.
REQ-015 The bus mux SHALL be combinational from the state register and inputs (zero latency).
REQ-016 In COPY, the outputs SHALL be:
- address = copier_address.
- ram_we_n, ram_cs_n, eeprom_oe_n, eeprom_cs_n = their copier_* counterparts.
- ram_oe_n = 1.
REQ-017 In RUN, the outputs SHALL be:
- address = cpu_address.
- ram_cs_n = cpu_mreq_n.
- ram_oe_n = cpu_mreq_n | cpu_rd_n.
- ram_we_n = cpu_mreq_n | cpu_wr_n.
- eeprom_cs_n = 1 and eeprom_oe_n = 1.
REQ-018 In IDLE, SETTLE, CPU_RESET and FAULT, address SHALL be 16'h0000 and all five strobes SHALL be 1.
REQ-019 An unreachable state encoding SHALL go to FAULT on the next cycle.

Reset
REQ-020 While reset_n=0 at a clock edge, the following SHALL hold:
- state = IDLE, counter = 0.
- copier_reset_n = 0, cpu_reset_n = 0.
- boot_done = 0, fault = 0.
- Bus outputs per REQ-018.
REQ-021 reset_n=0 in any state, including mid-COPY, SETTLE or RUN, SHALL abort the sequence and restart from IDLE after release.

Verification (SETTLE_CYCLES=4, CPU_RESET_CYCLES=8, COPY_TIMEOUT=100)
REQ-022 Nominal boot: release reset, then assert copier_done on the 40th COPY cycle. Required response:
- 4 SETTLE cycles, then 8 CPU_RESET cycles.
- Then cpu_reset_n=1 and boot_done=1, with fault=0 throughout.
REQ-023 Timeout: copier_done held 0. Required response:
- fault=1 after 100 COPY cycles.
- cpu_reset_n stays 0, boot_done=0, all strobes 1, address=0.
REQ-024 Coincident: copier_done=1 on COPY cycle 100. Required response: SETTLE entered, fault stays 0.
REQ-025 Bus mux check:
- In COPY, with copier_address=16'hE123 and copier_ram_we_n=0: address=16'hE123, ram_we_n=0, ram_oe_n=1.
- In RUN, with cpu_address=16'h1234, cpu_mreq_n=0, cpu_rd_n=0: address=16'h1234, ram_oe_n=0, ram_we_n=1, eeprom_cs_n=1.
REQ-026 Reset mid-SETTLE, with reset_n=0 for 1 cycle:
- IDLE next cycle, copier_reset_n=0, cpu_reset_n=0.
- The full sequence then repeats with identical timing.
REQ-027 Spurious done: copier_done toggled in RUN and in FAULT. Required response: state, boot_done, fault and cpu_reset_n unchanged.
